// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LEGv8 pipeline: load-use stalls,
// taken-branch flushes and memory req/ack freezes with timeout abort.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_Ra,
  input  logic [4:0]       id_Rb,
  input  logic             id_useRa,
  input  logic             id_useRb,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_Rw,
  input  logic             mem_brTaken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic lu_hazard;
  logic freeze;
  logic resolve;
  logic expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                              input logic             inc);
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  // XZR is hardwired zero, so a load targeting it never produces a dependency
  assign lu_hazard = ex_MemRead && (ex_Rw != 5'd31) &&
                     ((id_useRa && (id_Ra == ex_Rw)) ||
                      (id_useRb && (id_Rb == ex_Rw)));

  // freeze: hold the front of the pipe; resolve: apply branch/load-use/normal;
  // expire: abandon the access and release the pipe
  always_comb begin
    freeze  = 1'b0;
    resolve = 1'b0;
    expire  = 1'b0;
    if (state_q == S_RUN) begin
      if (mem_req && !mem_ack) freeze  = 1'b1;
      else                     resolve = 1'b1;
    end else begin
      if (mem_ack)                 resolve = 1'b1;
      else if (wait_q < TIMEOUT)   freeze  = 1'b1;
      else                         expire  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    if (freeze) begin
      state_d = S_WAIT;
      wait_d  = (state_q == S_RUN) ? 16'd1 : wait_q + 16'd1;
    end else begin
      state_d = S_RUN;
      wait_d  = '0;
      if (expire) err_d = 1'b1;
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (reset) begin
      if (freeze) begin
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (resolve && mem_brTaken) begin
        pc_en       = 1'b1;
        pc_sel      = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (resolve && lu_hazard) begin
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end
    end
  end

  // pc_sel is high exactly on taken-branch flush cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= sat_inc(stall_q, !pc_en);
      flush_q <= sat_inc(flush_q, pc_sel);
    end
  end

  assign mem_err   = err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
